// File: rtl/i2c_pkg.sv
// Types and constants shared by the I2C register sequencer and its register bank.
package i2c_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PTR   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } seq_state_t;

  localparam byte_t TX_FILL = 8'hFF;

endpackage

// File: rtl/i2c_reg_bank.sv
// Read/write configuration storage with one write port and a combinational
// read mux covering the whole address space, read-only status included.
module i2c_reg_bank
  import i2c_pkg::*;
#(
  parameter  int DEPTH   = 16,
  parameter  int RW_REGS = 8,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         we,
  input  logic [AW-1:0]                addr,
  input  byte_t                        wdata,
  input  logic [AW-1:0]                raddr,
  input  logic [(DEPTH-RW_REGS)*8-1:0] status_in,
  output byte_t                        rdata,
  output logic [RW_REGS*8-1:0]         cfg_out
);

  byte_t mem    [RW_REGS];
  byte_t rd_map [DEPTH];

  // Storage write; the sequencer only raises we for read/write addresses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RW_REGS; i++) mem[i] <= 8'h00;
    end else if (we) begin
      for (int i = 0; i < RW_REGS; i++) begin
        if (addr == AW'(i)) mem[i] <= wdata;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_map
    if (g < RW_REGS) begin : g_rw
      assign rd_map[g]          = mem[g];
      assign cfg_out[g*8 +: 8]  = mem[g];
    end else begin : g_ro
      assign rd_map[g] = status_in[(g-RW_REGS)*8 +: 8];
    end
  end

  assign rdata = rd_map[raddr];

endmodule

// File: rtl/i2c_reg_sequencer.sv
// I2C slave transaction controller: pointer/write/read sequencing over the
// register bank, local-port write arbitration (I2C first) and a sticky error.
module i2c_reg_sequencer
  import i2c_pkg::*;
#(
  parameter  int DEPTH   = 16,
  parameter  int RW_REGS = 8,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         txn_start,
  input  logic                         txn_rw,
  input  logic                         txn_stop,
  input  logic                         rx_valid,
  input  logic [7:0]                   rx_data,
  input  logic                         tx_req,
  output logic                         tx_load,
  output logic [7:0]                   tx_data,
  input  logic                         loc_we,
  input  logic [AW-1:0]                loc_addr,
  input  logic [7:0]                   loc_wdata,
  output logic                         loc_ack,
  input  logic [(DEPTH-RW_REGS)*8-1:0] status_in,
  output logic [RW_REGS*8-1:0]         cfg_out,
  output logic                         err,
  input  logic                         err_clr
);

  // One extra bit so RW_REGS == DEPTH still compares correctly.
  localparam logic [AW:0] RW_LIMIT = (AW+1)'(RW_REGS);

  seq_state_t    state;
  logic [AW-1:0] pointer;
  logic          ptr_rw;
  logic          loc_rw;
  logic          i2c_wr;
  logic          loc_accept;
  logic          new_err;
  logic          bank_we;
  logic [AW-1:0] bank_addr;
  byte_t         bank_wdata;
  byte_t         rd_data;

  i2c_reg_bank #(
    .DEPTH   (DEPTH),
    .RW_REGS (RW_REGS)
  ) u_bank (
    .clock     (clock),
    .reset     (reset),
    .we        (bank_we),
    .addr      (bank_addr),
    .wdata     (bank_wdata),
    .raddr     (pointer),
    .status_in (status_in),
    .rdata     (rd_data),
    .cfg_out   (cfg_out)
  );

  // Write-port arbitration and error detection; a request is ignored in its ack cycle.
  always_comb begin
    ptr_rw     = ({1'b0, pointer} < RW_LIMIT);
    loc_rw     = ({1'b0, loc_addr} < RW_LIMIT);
    i2c_wr     = rx_valid && (state == WDATA) && ptr_rw;
    loc_accept = loc_we && !loc_ack && !i2c_wr;
    bank_we    = i2c_wr || (loc_accept && loc_rw);
    if (i2c_wr) begin
      bank_addr  = pointer;
      bank_wdata = rx_data;
    end else begin
      bank_addr  = loc_addr;
      bank_wdata = loc_wdata;
    end
    new_err = (rx_valid && (state != PTR) && !((state == WDATA) && ptr_rw))
           || (tx_req && (state != RDATA))
           || (loc_accept && !loc_rw);
  end

  // Sequencer FSM with pointer, transmit register, local ack and sticky error.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pointer <= '0;
      tx_load <= 1'b0;
      tx_data <= 8'h00;
      loc_ack <= 1'b0;
      err     <= 1'b0;
    end else begin
      tx_load <= 1'b0;
      loc_ack <= loc_accept;
      case (state)
        IDLE:  state <= IDLE;
        PTR: begin
          if (rx_valid) begin
            pointer <= rx_data[AW-1:0];
            state   <= WDATA;
          end
        end
        WDATA: begin
          if (rx_valid) pointer <= pointer + AW'(1);
        end
        RDATA: begin
          if (tx_req) begin
            tx_data <= rd_data;
            tx_load <= 1'b1;
            pointer <= pointer + AW'(1);
          end
        end
        default: state <= IDLE;
      endcase
      // The slave never stalls: answer out-of-place requests with filler.
      if (tx_req && (state != RDATA)) begin
        tx_data <= TX_FILL;
        tx_load <= 1'b1;
      end
      if (txn_start) begin
        state <= txn_rw ? RDATA : PTR;
      end else if (txn_stop) begin
        state <= IDLE;
      end
      if (new_err) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Self-checking bench for i2c_reg_sequencer: directed vector table, corner
// sequences, then random traffic against a behavioural model.
module tb_i2c_reg_sequencer;
  import i2c_pkg::*;

  localparam int DEPTH   = 16;
  localparam int RW_REGS = 8;
  localparam int AW      = 4;

  localparam int K_NONE = 0, K_SW = 1, K_SR = 2, K_STOP = 3, K_RX = 4, K_TX = 5, K_CLR = 6;
  localparam int M_IDLE = 0, M_PTR = 1, M_WR = 2, M_RD = 3;

  logic                         clock = 1'b0;
  logic                         reset;
  logic                         txn_start, txn_rw, txn_stop;
  logic                         rx_valid;
  logic [7:0]                   rx_data;
  logic                         tx_req;
  logic                         tx_load;
  logic [7:0]                   tx_data;
  logic                         loc_we;
  logic [AW-1:0]                loc_addr;
  logic [7:0]                   loc_wdata;
  logic                         loc_ack;
  logic [(DEPTH-RW_REGS)*8-1:0] status_in;
  logic [RW_REGS*8-1:0]         cfg_out;
  logic                         err;
  logic                         err_clr;

  int total = 0;
  int bad   = 0;

  i2c_reg_sequencer #(.DEPTH(DEPTH), .RW_REGS(RW_REGS)) dut (
    .clock(clock), .reset(reset), .txn_start(txn_start), .txn_rw(txn_rw),
    .txn_stop(txn_stop), .rx_valid(rx_valid), .rx_data(rx_data), .tx_req(tx_req),
    .tx_load(tx_load), .tx_data(tx_data), .loc_we(loc_we), .loc_addr(loc_addr),
    .loc_wdata(loc_wdata), .loc_ack(loc_ack), .status_in(status_in),
    .cfg_out(cfg_out), .err(err), .err_clr(err_clr)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         kind;
    logic [7:0] d;
    logic       load;
    logic [7:0] txd;
    logic       e;
    int         idx;
    logic [7:0] cfg;
  } vec_t;

  vec_t vt[$];

  // behavioural model state for the random phase
  logic [7:0] m_regs [RW_REGS];
  int         m_ptr, m_st;
  logic       m_err, m_load;
  logic [7:0] m_tx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply(input int kind, input logic [7:0] d);
    case (kind)
      K_SW:    begin txn_start = 1'b1; txn_rw = 1'b0; end
      K_SR:    begin txn_start = 1'b1; txn_rw = 1'b1; end
      K_STOP:  txn_stop = 1'b1;
      K_RX:    begin rx_valid = 1'b1; rx_data = d; end
      K_TX:    tx_req = 1'b1;
      K_CLR:   err_clr = 1'b1;
      default: ;
    endcase
    step();
    txn_start = 1'b0; txn_stop = 1'b0; rx_valid = 1'b0; tx_req = 1'b0; err_clr = 1'b0;
  endtask

  task automatic wait_ack(input string name);
    for (int i = 0; i < 4 && !loc_ack; i++) step();
    chk(name, loc_ack, 1'b1);
  endtask

  function automatic logic [7:0] full_byte(input int a);
    if (a < RW_REGS) return m_regs[a];
    else return status_in[(a-RW_REGS)*8 +: 8];
  endfunction

  function automatic logic [63:0] model_cfg();
    logic [63:0] v;
    for (int i = 0; i < RW_REGS; i++) v[i*8 +: 8] = m_regs[i];
    return v;
  endfunction

  initial begin
    reset = 1'b1; txn_start = 1'b0; txn_rw = 1'b0; txn_stop = 1'b0;
    rx_valid = 1'b0; rx_data = 8'h00; tx_req = 1'b0; loc_we = 1'b0;
    loc_addr = '0; loc_wdata = 8'h00; err_clr = 1'b0;
    status_in = 64'h8786_8584_8382_815A;

    // kind, data, load, tx_data, err, cfg index, cfg byte
    vt.push_back('{K_SW,   8'h00, 1'b0, 8'h00, 1'b0, 3, 8'h00});
    vt.push_back('{K_RX,   8'h05, 1'b0, 8'h00, 1'b0, 5, 8'h00});
    vt.push_back('{K_RX,   8'h55, 1'b0, 8'h00, 1'b0, 5, 8'h55});
    vt.push_back('{K_SW,   8'h00, 1'b0, 8'h00, 1'b0, 5, 8'h55});
    vt.push_back('{K_RX,   8'h03, 1'b0, 8'h00, 1'b0, 3, 8'h00});
    vt.push_back('{K_RX,   8'hAA, 1'b0, 8'h00, 1'b0, 3, 8'hAA});
    vt.push_back('{K_RX,   8'hBB, 1'b0, 8'h00, 1'b0, 4, 8'hBB});
    vt.push_back('{K_SR,   8'h00, 1'b0, 8'h00, 1'b0, 4, 8'hBB});
    vt.push_back('{K_TX,   8'h00, 1'b1, 8'h55, 1'b0, 5, 8'h55});
    vt.push_back('{K_STOP, 8'h00, 1'b0, 8'h55, 1'b0, 3, 8'hAA});
    vt.push_back('{K_SW,   8'h00, 1'b0, 8'h55, 1'b0, 0, 8'h00});
    vt.push_back('{K_RX,   8'h0F, 1'b0, 8'h55, 1'b0, 0, 8'h00});
    vt.push_back('{K_RX,   8'h11, 1'b0, 8'h55, 1'b1, 0, 8'h00});
    vt.push_back('{K_RX,   8'h22, 1'b0, 8'h55, 1'b1, 0, 8'h22});
    vt.push_back('{K_CLR,  8'h00, 1'b0, 8'h55, 1'b0, 0, 8'h22});
    vt.push_back('{K_SW,   8'h00, 1'b0, 8'h55, 1'b0, 2, 8'h00});
    vt.push_back('{K_RX,   8'h02, 1'b0, 8'h55, 1'b0, 2, 8'h00});
    vt.push_back('{K_SR,   8'h00, 1'b0, 8'h55, 1'b0, 2, 8'h00});
    vt.push_back('{K_TX,   8'h00, 1'b1, 8'h00, 1'b0, 3, 8'hAA});
    vt.push_back('{K_TX,   8'h00, 1'b1, 8'hAA, 1'b0, 4, 8'hBB});
    vt.push_back('{K_NONE, 8'h00, 1'b0, 8'hAA, 1'b0, 4, 8'hBB});
    vt.push_back('{K_TX,   8'h00, 1'b1, 8'hBB, 1'b0, 4, 8'hBB});
    vt.push_back('{K_SW,   8'h00, 1'b0, 8'hBB, 1'b0, 0, 8'h22});
    vt.push_back('{K_RX,   8'h08, 1'b0, 8'hBB, 1'b0, 0, 8'h22});
    vt.push_back('{K_SR,   8'h00, 1'b0, 8'hBB, 1'b0, 0, 8'h22});
    vt.push_back('{K_TX,   8'h00, 1'b1, 8'h5A, 1'b0, 0, 8'h22});
    vt.push_back('{K_STOP, 8'h00, 1'b0, 8'h5A, 1'b0, 0, 8'h22});
    vt.push_back('{K_TX,   8'h00, 1'b1, 8'hFF, 1'b1, 0, 8'h22});
    vt.push_back('{K_CLR,  8'h00, 1'b0, 8'hFF, 1'b0, 0, 8'h22});
    vt.push_back('{K_RX,   8'h33, 1'b0, 8'hFF, 1'b1, 0, 8'h22});
    vt.push_back('{K_CLR,  8'h00, 1'b0, 8'hFF, 1'b0, 0, 8'h22});
    vt.push_back('{K_SW,   8'h00, 1'b0, 8'hFF, 1'b0, 0, 8'h22});
    vt.push_back('{K_RX,   8'h0F, 1'b0, 8'hFF, 1'b0, 0, 8'h22});
    vt.push_back('{K_SR,   8'h00, 1'b0, 8'hFF, 1'b0, 0, 8'h22});
    vt.push_back('{K_TX,   8'h00, 1'b1, 8'h87, 1'b0, 0, 8'h22});
    vt.push_back('{K_TX,   8'h00, 1'b1, 8'h22, 1'b0, 0, 8'h22});

    repeat (2) @(posedge clock);
    #1;
    chk("reset_tx_load", tx_load, 1'b0);
    chk("reset_tx_data", tx_data, 8'h00);
    chk("reset_loc_ack", loc_ack, 1'b0);
    chk("reset_err",     err,     1'b0);
    chk("reset_cfg",     cfg_out, 64'h0);
    reset = 1'b0;

    for (int r = 0; r < vt.size(); r++) begin
      apply(vt[r].kind, vt[r].d);
      chk($sformatf("vec%0d_tx_load", r), tx_load, vt[r].load);
      chk($sformatf("vec%0d_tx_data", r), tx_data, vt[r].txd);
      chk($sformatf("vec%0d_err", r),     err,     vt[r].e);
      chk($sformatf("vec%0d_cfg", r),     cfg_out[vt[r].idx*8 +: 8], vt[r].cfg);
    end

    // collision: I2C write wins, local write lands afterwards
    apply(K_SW, 8'h00);
    apply(K_RX, 8'h03);
    rx_valid = 1'b1; rx_data = 8'h44;
    loc_we = 1'b1; loc_addr = 4'd3; loc_wdata = 8'h77;
    step();
    rx_valid = 1'b0;
    chk("coll_i2c_first", cfg_out[3*8 +: 8], 8'h44);
    chk("coll_no_ack",    loc_ack, 1'b0);
    wait_ack("coll_ack");
    loc_we = 1'b0;
    chk("coll_final", cfg_out[3*8 +: 8], 8'h77);
    step();
    chk("coll_ack_pulse", loc_ack, 1'b0);

    // request held past its ack is a second request
    loc_we = 1'b1; loc_addr = 4'd1; loc_wdata = 8'h66;
    step(); chk("hold_ack1", loc_ack, 1'b1);
    step(); chk("hold_gap",  loc_ack, 1'b0);
    step(); chk("hold_ack2", loc_ack, 1'b1);
    loc_we = 1'b0;
    step(); chk("hold_end",  loc_ack, 1'b0);

    // local write to a read-only address
    loc_we = 1'b1; loc_addr = 4'd9; loc_wdata = 8'hEE;
    wait_ack("ro_ack");
    loc_we = 1'b0;
    chk("ro_err", err, 1'b1);
    chk("ro_cfg", cfg_out, 64'h0000_55BB_7700_6622);

    // clear coinciding with a new error keeps err set
    err_clr = 1'b1; tx_req = 1'b1;
    step();
    err_clr = 1'b0; tx_req = 1'b0;
    chk("clr_vs_err",  err,     1'b1);
    chk("clr_tx_fill", tx_data, 8'hFF);
    apply(K_CLR, 8'h00);
    chk("clr_done", err, 1'b0);

    // reset between tx_req and its tx_load
    apply(K_STOP, 8'h00);
    apply(K_TX, 8'h00);
    apply(K_SW, 8'h00);
    apply(K_RX, 8'h06);
    apply(K_SR, 8'h00);
    tx_req = 1'b1;
    #3;
    reset = 1'b1;
    @(posedge clock);
    #1;
    tx_req = 1'b0;
    chk("midrst_load", tx_load, 1'b0);
    chk("midrst_cfg",  cfg_out, 64'h0);
    chk("midrst_err",  err,     1'b0);
    chk("midrst_txd",  tx_data, 8'h00);
    #2;
    reset = 1'b0;
    loc_we = 1'b1; loc_addr = 4'd0; loc_wdata = 8'h9C;
    wait_ack("midrst_loc_ack");
    loc_we = 1'b0;
    apply(K_SR, 8'h00);
    apply(K_TX, 8'h00);
    chk("midrst_ptr0", tx_data, 8'h9C);

    // random traffic against the model
    status_in = {$urandom, $urandom};
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < RW_REGS; i++) m_regs[i] = 8'h00;
    m_ptr = 0; m_st = M_IDLE; m_err = 1'b0; m_tx = 8'h00;
    for (int n = 0; n < 300; n++) begin
      int op;
      int kind;
      logic [7:0] d;
      op = $urandom_range(0, 9);
      d = 8'($urandom);
      m_load = 1'b0;
      kind = K_NONE;
      case (op)
        1: begin kind = K_SW;   m_st = M_PTR;  end
        2: begin kind = K_SR;   m_st = M_RD;   end
        3: begin kind = K_STOP; m_st = M_IDLE; end
        4, 5, 6: begin
          kind = K_RX;
          if (m_st == M_PTR) begin
            m_ptr = int'(d) % DEPTH;
            m_st  = M_WR;
          end else if (m_st == M_WR) begin
            if (m_ptr < RW_REGS) m_regs[m_ptr] = d;
            else m_err = 1'b1;
            m_ptr = (m_ptr + 1) % DEPTH;
          end else begin
            m_err = 1'b1;
          end
        end
        7, 8: begin
          kind = K_TX;
          m_load = 1'b1;
          if (m_st == M_RD) begin
            m_tx  = full_byte(m_ptr);
            m_ptr = (m_ptr + 1) % DEPTH;
          end else begin
            m_tx  = 8'hFF;
            m_err = 1'b1;
          end
        end
        9: begin kind = K_CLR; m_err = 1'b0; end
        default: kind = K_NONE;
      endcase
      apply(kind, d);
      chk($sformatf("rnd%0d_tx_load", n), tx_load, m_load);
      chk($sformatf("rnd%0d_tx_data", n), tx_data, m_tx);
      chk($sformatf("rnd%0d_err", n),     err,     m_err);
      chk($sformatf("rnd%0d_cfg", n),     cfg_out, model_cfg());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_reg_sequencer.md
Name: i2c_reg_sequencer

Overview:
Transaction controller between the I2C slave byte interface and a bank of on-chip configuration/status registers.
- Interprets the first byte of a master-write as a register pointer, and subsequent bytes as register writes with pointer auto-increment.
- On a master-read, sequences bytes from the current pointer into the slave's transmit path.
- Arbitrates register write access between the I2C side and a local host port; I2C has priority.

Parameters:
DEPTH, 16, total register count; power of 2, at least 2.
RW_REGS, 8, registers 0..RW_REGS-1 are read/write; RW_REGS..DEPTH-1 are read-only status; 1 <= RW_REGS <= DEPTH.
AW, $clog2(DEPTH), pointer/address width; derived, do not override.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- txn_start  in  1  1-cycle pulse, slave decoded its own address (start or repeated start)
- txn_rw  in  1  master direction, sampled with txn_start: 1 = master reads, 0 = master writes
- txn_stop  in  1  1-cycle pulse on I2C stop
- rx_valid  in  1  1-cycle pulse, byte received from master
- rx_data  in  8  received byte, valid with rx_valid
- tx_req  in  1  1-cycle pulse, slave needs the next byte to transmit
- tx_load  out  1  1-cycle pulse, tx_data valid
- tx_data  out  8  byte to transmit
- loc_we  in  1  local write request; held until loc_ack
- loc_addr  in  AW  local write address
- loc_wdata  in  8  local write data
- loc_ack  out  1  1-cycle pulse, local write committed
- status_in  in  (DEPTH-RW_REGS)*8  read-only register contents; byte k maps to address RW_REGS+k
- cfg_out  out  RW_REGS*8  read/write register contents; byte k = register k
- err  out  1  sticky protocol error flag
- err_clr  in  1  clears err

Behaviour:
Reset values: all read/write registers 0x00, pointer 0, state IDLE, tx_load 0, tx_data 0x00, loc_ack 0, err 0.

State machine (states IDLE, PTR, WDATA, RDATA):
- txn_start in any state: txn_rw=0 -> PTR; txn_rw=1 -> RDATA. This handles repeated start. Pointer is kept.
- txn_stop in any state -> IDLE. If txn_stop and txn_start arrive in the same cycle, txn_start wins.
- PTR, on rx_valid: pointer <= rx_data[AW-1:0] (upper bits discarded, no error); go to WDATA.
- WDATA, on rx_valid:
  - pointer < RW_REGS: register[pointer] <= rx_data.
  - pointer >= RW_REGS: byte dropped, err set.
  - In both cases pointer <= pointer+1 mod DEPTH (wraps DEPTH-1 -> 0).
- RDATA, on tx_req: tx_data <= register[pointer] (status_in byte for read-only addresses); tx_load pulses; pointer <= pointer+1 mod DEPTH.
- rx_valid in IDLE or RDATA: ignored, err set.
- tx_req outside RDATA: tx_data <= 0xFF, tx_load pulses, err set, pointer unchanged. The slave must never stall.

Latency:
- rx_valid in cycle N -> cfg_out reflects the write in cycle N+1.
- tx_req in cycle N -> tx_load=1 with valid tx_data in cycle N+1.
- tx_data holds its value until the next load.

Local port arbitration:
- loc_we is accepted in any cycle with no I2C register write that cycle. Write commits; loc_ack pulses the next cycle.
- If an I2C write occurs in the same cycle, the local write waits. The requester keeps loc_we asserted.
- loc_addr >= RW_REGS: no write, loc_ack still pulses, err set.
- Request must drop in the cycle loc_ack is seen. loc_we still high after loc_ack is a new request.

Errors:
- err is sticky. err_clr clears it.
- If err_clr and a new error occur in the same cycle, err stays set.

Reset mid-transaction: immediate return to reset values; any in-flight tx_load or loc_ack is suppressed.

Decomposition:
- Package i2c_pkg:
  - typedef byte_t (logic [7:0])
  - enum seq_state_t {IDLE, PTR, WDATA, RDATA}
  - constant TX_FILL = 8'hFF
- Sub-module i2c_reg_bank:
  - holds the RW_REGS x 8 storage with a single write port (we, addr, wdata) and a combinational read mux that includes status_in.
  - The sequencer owns the FSM, pointer, arbitration, tx register and err.

Test Plan:
- Write txn: start(rw=0), rx 0x03, 0xAA, 0xBB -> cfg byte3=0xAA, byte4=0xBB, pointer=5, err=0.
- Wrap: start(rw=0), rx 0x0F, 0x11 -> byte 15 is read-only: dropped, err=1, pointer=0. Next rx 0x22 -> cfg byte0=0x22.
- Repeated-start read: write pointer 0x02, then start(rw=1), three tx_req -> tx_data 0x00 (byte2), byte3, byte4 values, each tx_load one cycle after its tx_req.
- Read of status: status_in byte0=0x5A, pointer=8, tx_req -> tx_data=0x5A.
- Collision: loc_we addr 3 data 0x77 in the same cycle as I2C rx writing addr 3 with 0x44 -> 0x44 first. loc_ack the following cycle or later; final byte3=0x77.
- Reset asserted between tx_req and tx_load -> no tx_load, cfg_out all zero, pointer 0, err 0.
